// File: rtl/decryption_pkg.sv
// ----------------------------------------------------------------------------
// decryption_pkg
// Shared constants for the decryption datapath and the plaintext packer.
//   SYS_DWIDTH  : width of one decrypted character
//   MST_DWIDTH  : width of one packed output word (LANES characters)
//   END_CHAR    : message terminator character
//   LANES       : characters per packed word
//   LANE_W      : width of the lane counter
//   BYTES_W     : width of the byte-count field (holds 0..LANES)
// ----------------------------------------------------------------------------
package decryption_pkg;

    localparam int SYS_DWIDTH = 8;
    localparam int MST_DWIDTH = 32;
    localparam logic [SYS_DWIDTH-1:0] END_CHAR = 8'hFA;

    localparam int LANES   = MST_DWIDTH / SYS_DWIDTH;
    localparam int LANE_W  = $clog2(LANES);
    localparam int BYTES_W = $clog2(LANES) + 1;

    // Width of a FIFO occupancy counter able to hold 0..depth.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead output (o_data is the head entry while
// the FIFO is non-empty, zero otherwise).
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push       : write request; accepted when not full, or when full and a
//                  pop happens in the same cycle
//   i_data       : entry to write
//   i_pop        : read request; ignored when empty
//   o_data       : head entry
//   o_empty      : FIFO holds no entries
//   o_level      : number of entries held (0..DEPTH)
//   o_drop       : combinational pulse, a push was refused this cycle
// Pointers carry one extra wrap bit so full and empty are told apart by the
// MSB compare: equal low bits with differing MSB means full.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    always_comb begin
        w_empty   = (r_wptr == r_rptr);
        w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        w_do_pop  = i_pop && !w_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        w_do_push = i_push && (!w_full || w_do_pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Storage is not reset: nothing is visible until a write has landed.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign o_empty = w_empty;
    assign o_level = r_wptr - r_rptr;
    assign o_drop  = i_push && w_full && !w_do_pop;

endmodule

// File: rtl/plaintext_packer.sv
// ----------------------------------------------------------------------------
// plaintext_packer
// Packs a stream of decrypted characters into MST_DWIDTH-bit words (lane 0 in
// the low byte) and buffers the words for a consumer with backpressure.
// A terminator character closes the current word early and marks it last;
// the terminator itself is never stored.
//   clk_sys    : clock, rising edge
//   rst        : asynchronous active-high reset
//   data_i     : decrypted character
//   valid_i    : data_i qualifier (no backpressure upstream)
//   data_o     : packed word at FIFO head
//   bytes_o    : valid bytes in data_o (0..4)
//   last_o     : word closes a message
//   valid_o    : FIFO non-empty
//   ready_i    : consumer takes the head word when valid_o & ready_i
//   level_o    : words buffered
//   overflow_o : sticky, a word was dropped because the FIFO was full
//   clr_i      : synchronous clear of overflow_o
// Handshake: a word transfers on a rising edge where valid_o and ready_i are
// both high; while valid_o is high and ready_i low, data_o/bytes_o/last_o
// hold. Completed words are staged one cycle before entering the FIFO, so a
// word appears on valid_o one cycle after the character that completed it.
// ----------------------------------------------------------------------------
module plaintext_packer
    import decryption_pkg::*;
#(
    parameter int SYS_DWIDTH = decryption_pkg::SYS_DWIDTH,
    parameter int MST_DWIDTH = decryption_pkg::MST_DWIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter logic [SYS_DWIDTH-1:0] END_CHAR = decryption_pkg::END_CHAR
) (
    input  logic                          clk_sys,
    input  logic                          rst,
    input  logic [SYS_DWIDTH-1:0]         data_i,
    input  logic                          valid_i,
    output logic [MST_DWIDTH-1:0]         data_o,
    output logic [2:0]                    bytes_o,
    output logic                          last_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    input  logic                          clr_i
);

    // FIFO entry layout: {last, bytes, word}
    localparam int FW = MST_DWIDTH + BYTES_W + 1;
    localparam logic [BYTES_W-1:0] FULL_BYTES = BYTES_W'(LANES);
    localparam logic [LANE_W-1:0]  LAST_LANE  = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0]  LANE_ONE   = LANE_W'(1);

    logic [LANE_W-1:0]     r_lane;
    logic [MST_DWIDTH-1:0] r_acc;
    logic                  r_push_valid;
    logic [FW-1:0]         r_push_word;
    logic                  r_overflow;

    logic [FW-1:0]         w_head;
    logic                  w_empty;
    logic                  w_drop;
    logic                  w_is_term;

    assign w_is_term = (data_i == END_CHAR);

    // Accumulator and staging register. Unfilled lanes stay zero because the
    // accumulator is cleared every time a word leaves it.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_lane       <= '0;
            r_acc        <= '0;
            r_push_valid <= 1'b0;
            r_push_word  <= '0;
        end else begin
            r_push_valid <= 1'b0;
            if (valid_i) begin
                if (w_is_term) begin
                    r_push_valid <= 1'b1;
                    r_push_word  <= {1'b1, {1'b0, r_lane}, r_acc};
                    r_acc        <= '0;
                    r_lane       <= '0;
                end else if (r_lane == LAST_LANE) begin
                    r_push_valid <= 1'b1;
                    r_push_word  <= {1'b0, FULL_BYTES, data_i,
                                     r_acc[MST_DWIDTH-SYS_DWIDTH-1:0]};
                    r_acc        <= '0;
                    r_lane       <= '0;
                end else begin
                    r_acc[int'(r_lane)*SYS_DWIDTH +: SYS_DWIDTH] <= data_i;
                    r_lane <= r_lane + LANE_ONE;
                end
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as clr_i keeps it set.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_i) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_sys),
        .i_rst   (rst),
        .i_push  (r_push_valid),
        .i_data  (r_push_word),
        .i_pop   (ready_i),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_level (level_o),
        .o_drop  (w_drop)
    );

    assign valid_o    = !w_empty;
    assign data_o     = w_head[MST_DWIDTH-1:0];
    assign bytes_o    = w_head[MST_DWIDTH +: BYTES_W];
    assign last_o     = w_head[FW-1];
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_plaintext_packer.sv
// ----------------------------------------------------------------------------
// tb_plaintext_packer
// Directed scenarios followed by a randomized run. The reference model keeps
// the message bytes of the word being built in a byte queue and the buffered
// words in exp_q (entries {last, bytes[2:0], data[31:0]}), with a one-cycle
// staging slot between a completed word and the buffer.
// ----------------------------------------------------------------------------
module tb_plaintext_packer;

    localparam int DEPTH = 4;
    localparam logic [7:0] TERM = 8'hFA;

    // ---------------- clock / reset ----------------
    logic        clk_sys = 1'b0;
    logic        rst     = 1'b1;
    logic [7:0]  data_i  = '0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        clr_i   = 1'b0;
    logic [31:0] data_o;
    logic [2:0]  bytes_o;
    logic        last_o;
    logic        valid_o;
    logic [2:0]  level_o;
    logic        overflow_o;

    always #5 clk_sys = ~clk_sys;

    plaintext_packer #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .bytes_o    (bytes_o),
        .last_o     (last_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .clr_i      (clr_i)
    );

    // ---------------- reference model ----------------
    logic [35:0] exp_q[$];
    logic [7:0]  acc_q[$];
    logic [35:0] pend;
    logic        pend_v;
    logic        ovf_m;
    int          checks;
    int          errors;

    function automatic logic [35:0] pack(input logic last);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < acc_q.size(); i++) begin
            w[8*i +: 8] = acc_q[i];
        end
        return {last, 3'(acc_q.size()), w};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid_o", 64'(valid_o), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("data_o",  64'(data_o),  64'(exp_q[0][31:0]));
            chk("bytes_o", 64'(bytes_o), 64'(exp_q[0][34:32]));
            chk("last_o",  64'(last_o),  64'(exp_q[0][35]));
        end
        chk("level_o",    64'(level_o),    64'(exp_q.size()));
        chk("overflow_o", 64'(overflow_o), 64'(ovf_m));
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drives one cycle of inputs, advances the
    // model across the next rising edge, then checks at the falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        logic pop;
        logic drop;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        clr_i   = c;
        pop  = (exp_q.size() != 0) && r;
        drop = 1'b0;
        if (pop) begin
            void'(exp_q.pop_front());
        end
        if (pend_v) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(pend);
            else drop = 1'b1;
        end
        if (drop) ovf_m = 1'b1;
        else if (c) ovf_m = 1'b0;
        pend_v = 1'b0;
        if (v) begin
            if (d == TERM) begin
                pend = pack(1'b1);
                pend_v = 1'b1;
                acc_q.delete();
            end else begin
                acc_q.push_back(d);
                if (acc_q.size() == 4) begin
                    pend = pack(1'b0);
                    pend_v = 1'b1;
                    acc_q.delete();
                end
            end
        end
        @(negedge clk_sys);
        check_outputs();
    endtask

    task automatic send(input logic [7:0] d, input logic r);
        step(1'b1, d, r, 1'b0);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, r, 1'b0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        clr_i   = 1'b0;
        exp_q.delete();
        acc_q.delete();
        pend_v = 1'b0;
        ovf_m  = 1'b0;
        @(negedge clk_sys);
        chk("rst_valid_o",    64'(valid_o),    64'(0));
        chk("rst_level_o",    64'(level_o),    64'(0));
        chk("rst_data_o",     64'(data_o),     64'(0));
        chk("rst_bytes_o",    64'(bytes_o),    64'(0));
        chk("rst_last_o",     64'(last_o),     64'(0));
        chk("rst_overflow_o", 64'(overflow_o), 64'(0));
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        pend   = '0;
        pend_v = 1'b0;
        ovf_m  = 1'b0;
        @(negedge clk_sys);
        do_reset();

        // Four characters with the consumer ready: one full word, valid_o
        // rising one cycle after the fourth character.
        send(8'h41, 1'b1); send(8'h42, 1'b1); send(8'h43, 1'b1); send(8'h44, 1'b1);
        chk("req34_not_yet", 64'(valid_o), 64'(0));
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("req34_valid", 64'(valid_o), 64'(1));
        chk("req34_word",  64'(data_o),  64'(32'h44434241));
        chk("req34_bytes", 64'(bytes_o), 64'(4));
        idle(2, 1'b1);

        // Short message: terminator after two characters; next char is lane 0.
        send(8'h41, 1'b0); send(8'h42, 1'b0); send(TERM, 1'b0);
        idle(1, 1'b0);
        chk("req35_word",  64'(data_o),  64'(32'h00004241));
        chk("req35_bytes", 64'(bytes_o), 64'(2));
        chk("req35_last",  64'(last_o),  64'(1));
        idle(2, 1'b1);
        send(8'h61, 1'b1); send(TERM, 1'b1);
        idle(1, 1'b0);
        chk("req35_lane0", 64'(data_o), 64'(32'h00000061));
        idle(2, 1'b1);

        // Bare terminator: zero-byte last word.
        send(TERM, 1'b0);
        idle(1, 1'b0);
        chk("req36_word",  64'(data_o),  64'(0));
        chk("req36_bytes", 64'(bytes_o), 64'(0));
        chk("req36_last",  64'(last_o),  64'(1));
        idle(2, 1'b1);

        // Consumer stalled, five words offered: fifth is dropped.
        for (int i = 0; i < 20; i++) send(8'(8'h10 + i), 1'b0);
        idle(2, 1'b0);
        chk("req37_level", 64'(level_o),    64'(4));
        chk("req37_ovf",   64'(overflow_o), 64'(1));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("req37_clr",   64'(overflow_o), 64'(0));
        chk("req37_head",  64'(data_o),     64'(32'h13121110));
        idle(6, 1'b1);

        // Full FIFO with a push landing in the same cycle as a pop.
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("req38_level", 64'(level_o),    64'(4));
        chk("req38_ovf",   64'(overflow_o), 64'(0));
        chk("req38_head",  64'(data_o),     64'(32'h87868584));
        idle(6, 1'b1);

        // Reset with one buffered word and a partial word.
        for (int i = 0; i < 6; i++) send(8'(8'h30 + i), 1'b0);
        idle(1, 1'b0);
        do_reset();
        send(8'h51, 1'b0); send(8'h52, 1'b0); send(8'h53, 1'b0); send(8'h54, 1'b0);
        idle(1, 1'b0);
        chk("req39_word", 64'(data_o), 64'(32'h54535251));
        idle(2, 1'b1);

        // Randomized traffic, alternating stalled and flowing phases.
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 60; i++) begin
                logic v;
                logic r;
                logic c;
                logic [7:0] d;
                v = ($urandom_range(0, 3) != 0);
                d = ($urandom_range(0, 7) == 0) ? TERM : 8'($urandom_range(0, 255));
                r = ph[0] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
                c = ($urandom_range(0, 15) == 0);
                step(v, d, r, c);
            end
        end
        idle(8, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
